chacha_stream_ctrl: RTL

CHACHA_STREAM_CTRL -- requirements
Module: chacha_stream_ctrl

---
 rtl/chacha_stream_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/chacha_stream_ctrl.sv
// ChaCha20 keystream job controller.
// Latches key/nonce/counter for a job, feeds the external block core one block at a time,
// buffers each core result and hands it to a valid/ready consumer with a final-block flag.
// Optional build macro CHACHA_CTRL_XOR_EN: adds a 512-bit din input and outputs buffer ^ din
// (ciphertext) instead of the raw keystream.
module chacha_stream_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [255:0]     key,
  input  logic [95:0]      nonce,
  input  logic [31:0]      ctr_init,
  input  logic [CNT_W-1:0] nblocks,
  output logic [511:0]     core_state_in,
  input  logic [511:0]     core_state_out,
  output logic             ks_valid,
  input  logic             ks_ready,
`ifdef CHACHA_CTRL_XOR_EN
  input  logic [511:0]     din,
`endif
  output logic [511:0]     ks_data,
  output logic             ks_last,
  output logic             busy,
  output logic             done,
  output logic             ctr_wrap
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StOut   = 3'd3,
    StFin   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [31:0]        ctr_q, ctr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [511:0]       buf_q, buf_d;
  logic               wrap_q, wrap_d;

  // Key and nonce chunks are byte strings; ChaCha loads each 4-byte group little-endian.
  function automatic logic [31:0] le32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Core input is always the latched job state with the current counter.
  always_comb begin
    core_state_in = '0;
    core_state_in[511:384] = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
    for (int i = 0; i < 8; i++) begin
      core_state_in[383-32*i -: 32] = le32(key_q[255-32*i -: 32]);
    end
    core_state_in[127:96] = ctr_q;
    for (int i = 0; i < 3; i++) begin
      core_state_in[95-32*i -: 32] = le32(nonce_q[95-32*i -: 32]);
    end
  end

  // Next-state logic for the job FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key;
          nonce_d = nonce;
          ctr_d   = ctr_init;
          rem_d   = nblocks;
          wrap_d  = 1'b0;
          state_d = (nblocks != '0) ? StIssue : StFin;
        end
      end
      // Core samples core_state_in at the end of this cycle.
      StIssue: state_d = StWait;
      // Core result is registered by now; capture it.
      StWait: begin
        buf_d   = core_state_out;
        state_d = StOut;
      end
      StOut: begin
        if (ks_ready) begin
          if (rem_q != CNT_W'(1)) begin
            rem_d   = rem_q - CNT_W'(1);
            ctr_d   = ctr_q + 32'd1;
            if (ctr_q == 32'hFFFF_FFFF) wrap_d = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      wrap_q  <= wrap_d;
    end
  end

  // Status and stream outputs decoded from the registered state.
  always_comb begin
    ks_valid = (state_q == StOut);
    ks_last  = (state_q == StOut) && (rem_q == CNT_W'(1));
    busy     = (state_q != StIdle);
    done     = (state_q == StFin);
    ctr_wrap = wrap_q;
`ifdef CHACHA_CTRL_XOR_EN
    ks_data  = buf_q ^ din;
`else
    ks_data  = buf_q;
`endif
  end

endmodule
